// File: rtl/sensor_driver.sv
`default_nettype none
// ============================================================================
// Module      : sensor_driver
// Description : HC-SR04 ultrasonic ranging driver. A measure request issues a
//               fixed-width trigger pulse, then times the echo pulse in clock
//               cycles and converts it to an 8-bit saturated distance in cm
//               without a divider (sub-counter wraps every CYCLES_PER_CM).
// Ports       : clk      - system clock, rising edge
//               rst      - asynchronous active-low reset
//               measure  - start request, honoured only in IDLE
//               echo     - sensor echo pin (asynchronous, synchronised here)
//               trig     - sensor trigger pin (registered)
//               distance - last measured distance in cm, saturates at 255
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_driver #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int TRIG_CYCLES    = 500,
  parameter int CYCLES_PER_CM  = 2900,
  parameter int TIMEOUT_CYCLES = 1_900_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       measure,
  input  logic       echo,
  output logic       trig,
  output logic [7:0] distance
);

  // One shared counter covers trigger width, echo wait and echo width.
  localparam int c_MAX_CNT = (TIMEOUT_CYCLES > TRIG_CYCLES) ? TIMEOUT_CYCLES : TRIG_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
  localparam int c_SUB_W   = $clog2(CYCLES_PER_CM + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_ZERO     = '0;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_TRIG_LAST    = c_CNT_W'(TRIG_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [c_SUB_W-1:0] c_SUB_ZERO     = '0;
  localparam logic [c_SUB_W-1:0] c_SUB_ONE      = c_SUB_W'(1);
  localparam logic [c_SUB_W-1:0] c_SUB_LAST     = c_SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [7:0]         c_CM_MAX       = 8'hFF;

  // Elaboration-time parameter sanity checks.
  if (CLK_FREQ_HZ <= 0) begin : g_bad_clk
    $error("sensor_driver: CLK_FREQ_HZ must be positive");
  end
  if (CYCLES_PER_CM < 2 || TRIG_CYCLES < 1 || TIMEOUT_CYCLES < 2) begin : g_bad_timing
    $error("sensor_driver: CYCLES_PER_CM >= 2, TRIG_CYCLES >= 1, TIMEOUT_CYCLES >= 2 required");
  end

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_TRIGGER   = 2'd1,
    ST_WAIT_ECHO = 2'd2,
    ST_MEASURE   = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [c_SUB_W-1:0]   r_sub, w_sub_nxt;
  logic [7:0]           r_cm, w_cm_nxt;
  logic [7:0]           r_distance, w_distance_nxt;
  logic                 r_trig, w_trig_nxt;
  logic                 r_echo_s1, r_echo_s2;

  // State and datapath registers; the echo synchroniser shares the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= c_CNT_ZERO;
      r_sub      <= c_SUB_ZERO;
      r_cm       <= 8'd0;
      r_distance <= 8'd0;
      r_trig     <= 1'b0;
      r_echo_s1  <= 1'b0;
      r_echo_s2  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sub      <= w_sub_nxt;
      r_cm       <= w_cm_nxt;
      r_distance <= w_distance_nxt;
      r_trig     <= w_trig_nxt;
      r_echo_s1  <= echo;
      r_echo_s2  <= r_echo_s1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sub_nxt      = r_sub;
    w_cm_nxt       = r_cm;
    w_distance_nxt = r_distance;

    case (r_state)
      ST_IDLE: begin
        if (measure) begin
          w_state_nxt = ST_TRIGGER;
          w_cnt_nxt   = c_CNT_ZERO;
          w_sub_nxt   = c_SUB_ZERO;
          w_cm_nxt    = 8'd0;
        end
      end

      ST_TRIGGER: begin
        if (r_cnt == c_TRIG_LAST) begin
          w_state_nxt = ST_WAIT_ECHO;
          w_cnt_nxt   = c_CNT_ZERO;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      ST_WAIT_ECHO: begin
        if (r_echo_s2) begin
          // The first high cycle is already part of the echo width.
          w_state_nxt = ST_MEASURE;
          w_cnt_nxt   = c_CNT_ONE;
          w_sub_nxt   = c_SUB_ONE;
          w_cm_nxt    = 8'd0;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          w_state_nxt    = ST_IDLE;
          w_distance_nxt = c_CM_MAX;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end

      ST_MEASURE: begin
        if (!r_echo_s2) begin
          w_state_nxt    = ST_IDLE;
          w_distance_nxt = r_cm;
        end else if (r_cnt == c_TIMEOUT_LAST) begin
          // This cycle makes the width equal to the timeout.
          w_state_nxt    = ST_IDLE;
          w_distance_nxt = c_CM_MAX;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
          // Divider-free conversion: cm ticks each time sub wraps.
          if (r_sub == c_SUB_LAST) begin
            w_sub_nxt = c_SUB_ZERO;
            if (r_cm != c_CM_MAX) begin
              w_cm_nxt = r_cm + 8'd1;
            end
          end else begin
            w_sub_nxt = r_sub + c_SUB_ONE;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Registered trigger pin: high exactly while in TRIGGER.
    w_trig_nxt = (w_state_nxt == ST_TRIGGER);
  end

  assign trig     = r_trig;
  assign distance = r_distance;

endmodule
`default_nettype wire

// File: tb/tb_sensor_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_driver
// Description : Self-checking bench for sensor_driver with scaled timing
//               (TRIG 20, 10 clocks/cm, timeout 4000). Expected distances
//               come from a plain arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_driver;

  localparam int TRIG    = 20;
  localparam int CPC     = 10;
  localparam int TIMEOUT = 4000;

  logic       clk;
  logic       rst;
  logic       measure;
  logic       echo;
  logic       trig;
  logic [7:0] distance;

  int n_cmp  = 0;
  int n_fail = 0;
  int model_dist = 0;

  sensor_driver #(
    .CLK_FREQ_HZ   (50_000_000),
    .TRIG_CYCLES   (TRIG),
    .CYCLES_PER_CM (CPC),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .measure (measure),
    .echo    (echo),
    .trig    (trig),
    .distance(distance)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: width in synchronised-clock cycles -> saturated centimetres.
  function automatic int ref_dist(input int width);
    int q;
    if (width >= TIMEOUT) return 255;
    q = width / CPC;
    return (q > 255) ? 255 : q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Request a measurement and return the observed trigger width.
  task automatic start_measure(output int tw);
    measure = 1'b1;
    tick(1);
    measure = 1'b0;
    tw = 0;
    while (trig === 1'b1 && tw < TRIG + 10) begin
      tw++;
      tick(1);
    end
  endtask

  // Full measurement: echo of 'width' clocks begins 'dly' clocks after trig falls.
  task automatic do_measure(input string tag, input int dly, input int width, input bit pulse_mid);
    int tw;
    start_measure(tw);
    check({tag, "_trig_width"}, tw, TRIG);
    tick(dly);
    echo = 1'b1;
    for (int i = 0; i < width; i++) begin
      measure = (pulse_mid && i == width / 2);
      if (i == width / 2) check({tag, "_hold"}, distance, model_dist);
      tick(1);
    end
    measure = 1'b0;
    echo    = 1'b0;
    tick(4);
    model_dist = ref_dist(width);
    check({tag, "_dist"}, distance, model_dist);
    check({tag, "_trig_idle"}, trig, 0);
  endtask

  initial begin
    int tw;
    int w;
    int d;
    rst     = 1'b0;
    measure = 1'b0;
    echo    = 1'b0;
    tick(1);
    check("reset_trig", trig, 0);
    check("reset_dist", distance, 0);
    rst = 1'b1;
    tick(2);

    // Main function and boundaries (scaled from the full-rate values).
    do_measure("d100",    25, 1000, 1'b0);
    do_measure("w9",       3,    9, 1'b0);
    do_measure("w10",      3,   10, 1'b0);
    do_measure("w2550",    5, 2550, 1'b0);
    do_measure("w2560",    5, 2560, 1'b0);
    do_measure("w3440",    5, 3440, 1'b0);
    do_measure("stuck",    5, 4100, 1'b0);
    do_measure("after",    0,   37, 1'b0);

    // Echo arriving in IDLE is ignored.
    echo = 1'b1;
    tick(50);
    echo = 1'b0;
    tick(4);
    check("idle_echo_dist", distance, model_dist);
    check("idle_echo_trig", trig, 0);

    // No echo at all: times out to 255, then a new measure is accepted.
    do_measure("pre_to", 2, 9, 1'b0);
    start_measure(tw);
    check("to_trig_width", tw, TRIG);
    tick(TIMEOUT - 5);
    check("to_not_yet", distance, model_dist);
    tick(10);
    model_dist = 255;
    check("to_dist", distance, model_dist);
    do_measure("post_to", 1, 123, 1'b0);

    // Measure pulsed mid-echo is ignored.
    do_measure("mid_meas", 3, 537, 1'b1);

    // Randomised widths and start delays.
    for (int r = 0; r < 8; r++) begin
      w = $urandom_range(1, 3000);
      d = $urandom_range(0, 40);
      do_measure("rand", d, w, 1'b0);
    end

    // Asynchronous reset mid-echo.
    do_measure("pre_rst", 5, 777, 1'b0);
    start_measure(tw);
    check("rst_trig_width", tw, TRIG);
    tick(4);
    echo = 1'b1;
    tick(100);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_trig", trig, 0);
    check("rst_mid_dist", distance, 0);
    model_dist = 0;
    echo = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    do_measure("post_rst", 2, 1234, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sensor_driver.md
Name: sensor_driver

Overview:
Driver for an HC-SR04 ultrasonic ranging module.
- On a measure request it issues a fixed-width trigger pulse, then times the echo pulse width in clock cycles.
- It converts the width to centimetres and presents the result as an 8-bit saturated distance.
- It sits between the board-level sensor pins and user logic or LEDs.

Parameters:
- CLK_FREQ_HZ, 50_000_000, system clock frequency (20 ns period).
- TRIG_CYCLES, 500, trigger pulse width in clocks (10 us at 50 MHz).
- CYCLES_PER_CM, 2900, echo clocks per centimetre (58 us round trip per cm at 50 MHz).
- TIMEOUT_CYCLES, 1_900_000, maximum wait for echo rise, and maximum echo width (38 ms).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-low reset.
- measure  in  1  start request, sampled high in IDLE.
- echo  in  1  sensor echo pin, asynchronous to clk.
- trig  out  1  sensor trigger pin.
- distance  out  8  last measured distance in cm, saturating at 255.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - trig=0, distance=0.
  - All counters clear.
  - Echo synchronizer flops clear.
  - Reset mid-measurement aborts immediately; distance returns to 0.
- echo passes through a 2-flop synchronizer before use.
  - Both edges see the same 2-cycle delay, so measured width equals true width.
- States: IDLE, TRIGGER, WAIT_ECHO, MEASURE.
- IDLE:
  - trig=0.
  - measure=1 on a clock edge moves to TRIGGER and clears counters.
- TRIGGER:
  - trig=1 for exactly TRIG_CYCLES clocks; trig rises the cycle after measure is sampled.
  - Then trig=0 and the state moves to WAIT_ECHO.
- WAIT_ECHO:
  - Synchronized echo=1 moves to MEASURE and starts the width count at 1.
  - If TIMEOUT_CYCLES elapse with no echo, distance is set to 255 and the state returns to IDLE.
- MEASURE:
  - Sub-counter counts clocks while synced echo=1.
  - On reaching CYCLES_PER_CM the sub-counter wraps to 0 and the cm counter increments.
  - The cm counter saturates at 255 and never wraps.
  - On synced echo falling edge: distance <= cm counter, then state goes to IDLE.
  - If total echo width reaches TIMEOUT_CYCLES while echo is still high: distance <= 255, state goes to IDLE.
- Arithmetic: distance = min(255, floor(echo_high_cycles / CYCLES_PER_CM)). No divider is used.
- distance is updated only at end of measurement and holds its value between measurements.
- measure is ignored while not in IDLE. Holding measure high retriggers at the next IDLE cycle.
- An echo already high when WAIT_ECHO is entered counts from that cycle.
- An echo pulse arriving in IDLE or TRIGGER is ignored.
- Back-to-back measurement: the IDLE cycle after completion may accept measure immediately.

Test Plan:
- Reset: hold rst=0 for 1 cycle with echo=0 -> trig=0, distance=0. Release; measure=1 for 1 cycle -> trig high for exactly 500 clocks, then low.
- Echo pulse of 290,000 clocks starting 500 clocks after trig falls -> distance=100 about 2 cycles after echo falls.
- Boundaries:
  - Echo 2,899 clocks -> distance=0.
  - Echo 2,900 clocks -> distance=1.
  - Echo 739,500 clocks -> distance=255.
  - Echo 742,400 clocks -> distance=255, saturated.
- Echo 1,000,000 clocks (20 ms), as from a measure pulse -> distance=255 (saturated; 344 cm true). The FSM returns to IDLE and a new measure is accepted.
- No echo for 1,900,000 clocks after trigger -> distance=255 and the FSM returns to IDLE. Echo stuck high past 1,900,000 clocks -> distance=255.
- Ignore and abort cases:
  - measure pulsed during MEASURE -> ignored, result unchanged.
  - rst=0 asserted mid-echo -> trig=0, distance=0 immediately, FSM in IDLE.
